// File: rtl/conv_sched_pkg.sv
// Shared types and defaults for the convolution layer tile scheduler.
package conv_sched_pkg;

  localparam int SA_ROWS     = 16;
  localparam int DEF_OCG_W   = 8;
  localparam int DEF_PT_W    = 16;
  localparam int DEF_PERF_W  = 32;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_W  = 3'd1,
    S_WAIT_FM = 3'd2,
    S_FIRE    = 3'd3,
    S_COMPUTE = 3'd4,
    S_NEXT    = 3'd5,
    S_DONE    = 3'd6
  } sched_state_t;

endpackage

// File: rtl/sched_perf_cnt.sv
// Saturating event counter with synchronous clear; holds at all-ones.
module sched_perf_cnt
  import conv_sched_pkg::*;
#(
  parameter int W = DEF_PERF_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/conv_tile_scheduler.sv
// Layer scheduler: walks output-channel groups (outer) and pixel tiles (inner), one tile in flight.
// Optional performance counters are built when CONV_SCHED_PERF_EN is defined.
module conv_tile_scheduler
  import conv_sched_pkg::*;
#(
  parameter int OCG_W = DEF_OCG_W,
  parameter int PT_W  = DEF_PT_W
`ifdef CONV_SCHED_PERF_EN
  ,
  parameter int PERF_W = DEF_PERF_W
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cfg_mode,
  input  logic [31:0]       cfg_nif_mult_k_mult_k,
  input  logic [OCG_W-1:0]  cfg_last_ocg,
  input  logic [PT_W-1:0]   cfg_last_pt,
  output logic              wload_req,
  input  logic              wload_ack,
  input  logic              fm_valid,
  output logic              re_fm_en,
  input  logic              tile_done,
  output logic              mode,
  output logic [31:0]       nif_mult_k_mult_k,
  output logic [OCG_W-1:0]  ocg_idx,
  output logic [PT_W-1:0]   pt_idx,
  output logic              busy,
  output logic              done,
  output logic [2:0]        state_dbg
`ifdef CONV_SCHED_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_busy_cycles,
  output logic [PERF_W-1:0] perf_fm_stall_cycles
`endif
);

  // Handshakes: wload_req is a level held for the whole of LOAD_W and wload_ack is a
  // one-cycle reply sampled only there; fm_valid is a level sampled only in WAIT_FM;
  // re_fm_en and tile_done are single-cycle strobes, tile_done sampled only in COMPUTE.
  sched_state_t     state, state_nxt;
  logic [OCG_W-1:0] last_ocg_q;
  logic [PT_W-1:0]  last_pt_q;
  logic             start_acc;
  logic             more_pt, more_ocg;

  assign start_acc = (state == S_IDLE) && start;
  assign more_pt   = pt_idx < last_pt_q;
  assign more_ocg  = ocg_idx < last_ocg_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_LOAD_W;
      S_LOAD_W:  if (wload_ack) state_nxt = S_WAIT_FM;
      S_WAIT_FM: if (fm_valid) state_nxt = S_FIRE;
      S_FIRE:    state_nxt = S_COMPUTE;
      S_COMPUTE: if (tile_done) state_nxt = S_NEXT;
      S_NEXT: begin
        if (more_pt) begin
          state_nxt = S_WAIT_FM;
        end else if (more_ocg) begin
          state_nxt = S_LOAD_W;
        end else begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    wload_req = 1'b0;
    re_fm_en  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      S_IDLE:   busy      = 1'b0;
      S_LOAD_W: wload_req = 1'b1;
      S_FIRE:   re_fm_en  = 1'b1;
      S_DONE:   done      = 1'b1;
      default:  ;
    endcase
  end

  assign state_dbg = state;

  // Indices only move in NEXT, so they stay put from FIRE through COMPUTE for write-back.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode              <= 1'b0;
      nif_mult_k_mult_k <= '0;
      last_ocg_q        <= '0;
      last_pt_q         <= '0;
      ocg_idx           <= '0;
      pt_idx            <= '0;
    end else if (start_acc) begin
      mode              <= cfg_mode;
      nif_mult_k_mult_k <= cfg_nif_mult_k_mult_k;
      last_ocg_q        <= cfg_last_ocg;
      last_pt_q         <= cfg_last_pt;
      ocg_idx           <= '0;
      pt_idx            <= '0;
    end else if (state == S_NEXT) begin
      if (more_pt) begin
        pt_idx <= pt_idx + 1'b1;
      end else if (more_ocg) begin
        pt_idx  <= '0;
        ocg_idx <= ocg_idx + 1'b1;
      end
    end
  end

`ifdef CONV_SCHED_PERF_EN
  sched_perf_cnt #(.W(PERF_W)) u_busy_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (start_acc),
    .en    (busy),
    .count (perf_busy_cycles)
  );

  sched_perf_cnt #(.W(PERF_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (start_acc),
    .en    ((state == S_WAIT_FM) && !fm_valid),
    .count (perf_fm_stall_cycles)
  );
`endif

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Directed bench for conv_tile_scheduler: emulates weight loader, FM buffer and tile controller.
module tb_conv_tile_scheduler;
  import conv_sched_pkg::*;

  localparam int OCG_W = DEF_OCG_W;
  localparam int PT_W  = DEF_PT_W;
  localparam int IW    = OCG_W + PT_W;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             reset, start, cfg_mode;
  logic [31:0]      cfg_nif_mult_k_mult_k;
  logic [OCG_W-1:0] cfg_last_ocg;
  logic [PT_W-1:0]  cfg_last_pt;
  logic             wload_req, wload_ack, fm_valid, re_fm_en, tile_done;
  logic             mode, busy, done;
  logic [31:0]      nif_mult_k_mult_k;
  logic [OCG_W-1:0] ocg_idx;
  logic [PT_W-1:0]  pt_idx;
  logic [2:0]       state_dbg;
`ifdef CONV_SCHED_PERF_EN
  logic [DEF_PERF_W-1:0] perf_busy_cycles, perf_fm_stall_cycles;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  conv_tile_scheduler dut (
    .clk                   (clk),
    .reset                 (reset),
    .start                 (start),
    .cfg_mode              (cfg_mode),
    .cfg_nif_mult_k_mult_k (cfg_nif_mult_k_mult_k),
    .cfg_last_ocg          (cfg_last_ocg),
    .cfg_last_pt           (cfg_last_pt),
    .wload_req             (wload_req),
    .wload_ack             (wload_ack),
    .fm_valid              (fm_valid),
    .re_fm_en              (re_fm_en),
    .tile_done             (tile_done),
    .mode                  (mode),
    .nif_mult_k_mult_k     (nif_mult_k_mult_k),
    .ocg_idx               (ocg_idx),
    .pt_idx                (pt_idx),
    .busy                  (busy),
    .done                  (done),
    .state_dbg             (state_dbg)
`ifdef CONV_SCHED_PERF_EN
    ,
    .perf_busy_cycles      (perf_busy_cycles),
    .perf_fm_stall_cycles  (perf_fm_stall_cycles)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [IW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  logic             exp_mode;
  logic [31:0]      exp_nif;
  logic [OCG_W-1:0] exp_last_ocg;
  logic [PT_W-1:0]  exp_last_pt;

  // environment knobs and per-layer results
  int ack_dly, done_dly, stall_n, abort_tile;
  bit spur_en, gap_chk;
  int tiles, wreq_eps, done_pulses;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_state"}, state_dbg, S_IDLE);
    chk({tag, "_wload_req"}, wload_req, 1'b0);
    chk({tag, "_re_fm_en"}, re_fm_en, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_mode"}, mode, 1'b0);
    chk({tag, "_nif"}, nif_mult_k_mult_k, 32'd0);
    chk({tag, "_idx"}, {ocg_idx, pt_idx}, {IW{1'b0}});
`ifdef CONV_SCHED_PERF_EN
    chk({tag, "_perf_busy"}, perf_busy_cycles, 0);
    chk({tag, "_perf_stall"}, perf_fm_stall_cycles, 0);
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_layer(input logic m, input logic [31:0] nif, input int lo, input int lp);
    cfg_mode              = m;
    cfg_nif_mult_k_mult_k = nif;
    cfg_last_ocg          = OCG_W'(lo);
    cfg_last_pt           = PT_W'(lp);
    exp_mode     = m;
    exp_nif      = nif;
    exp_last_ocg = OCG_W'(lo);
    exp_last_pt  = PT_W'(lp);
    for (int o = 0; o <= lo; o++)
      for (int p = 0; p <= lp; p++)
        exp_q.push_back({OCG_W'(o), PT_W'(p)});
    start = 1'b1;
  endtask

  // Plays weight loader, FM buffer and tile controller one cycle at a time until the
  // layer finishes (or is aborted by reset), checking handshake latencies on the way.
  task automatic run_layer(input int budget);
    int ack_cnt, td_cnt, stall_left, rise_cyc, last_ack, last_td, last_fire, first_cyc, done_cyc;
    bit prev_wreq, first, spur_pend, abort_arm, finished;
    logic [2:0] spur_state;
    logic [IW-1:0] spur_idx, prev_idx;
    ack_cnt = -1; td_cnt = -1; stall_left = stall_n; rise_cyc = -1;
    last_ack = -1; last_td = -1; last_fire = -1; first_cyc = 0; done_cyc = -1;
    prev_wreq = 0; first = 1; spur_pend = 0; abort_arm = 0; finished = 0;
    spur_state = '0; spur_idx = '0; prev_idx = '0;
    tiles = 0; wreq_eps = 0; done_pulses = 0;
    for (int c = 0; c < budget && !finished; c++) begin
      @(posedge clk); #1;
      start = 1'b0; wload_ack = 1'b0; tile_done = 1'b0;
      if (reset) begin
        reset = 1'b0;
        check_reset_outputs("abort_rst");
        exp_q.delete();
        finished = 1;
      end else if (abort_arm) begin
        chk("abort_in_compute", state_dbg, S_COMPUTE);
        reset = 1'b1;
        abort_arm = 0;
      end else begin
        if (first) begin
          chk("start_busy", busy, 1'b1);
          chk("start_wreq", wload_req, 1'b1);
          first_cyc = cyc;
          first = 0;
        end
        if (spur_pend) begin
          chk("spur_state", state_dbg, spur_state);
          chk("spur_idx", {ocg_idx, pt_idx}, spur_idx);
          spur_pend = 0;
        end
        if (wload_req && !prev_wreq) begin
          wreq_eps++;
          ack_cnt = ack_dly;
        end
        prev_wreq = wload_req;
        if (ack_cnt == 0) begin
          wload_ack = 1'b1; ack_cnt = -1; last_ack = cyc;
        end else if (ack_cnt > 0) begin
          ack_cnt--;
        end
        if (state_dbg == S_WAIT_FM && stall_left > 0) begin
          fm_valid = 1'b0;
          stall_left--;
          if (spur_en) begin
            tile_done = 1'b1; wload_ack = 1'b1;
            spur_pend = 1; spur_state = S_WAIT_FM; spur_idx = {ocg_idx, pt_idx};
          end
        end else if (!fm_valid) begin
          fm_valid = 1'b1;
          rise_cyc = cyc;
        end
        if (re_fm_en) begin
          tiles++;
          chk("tile_expected", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) chk("tile_idx", {ocg_idx, pt_idx}, exp_q.pop_front());
          if (rise_cyc >= 0) begin
            chk("fire_after_fm", cyc, rise_cyc + 1);
            rise_cyc = -1;
          end else if (last_ack > last_fire) begin
            chk("fire_after_ack", cyc, last_ack + 2);
          end else begin
            chk("fire_after_done", cyc, last_td + 3);
          end
          if (gap_chk && last_fire >= 0 && ocg_idx == prev_idx[IW-1:PT_W])
            chk("fire_gap", cyc - last_fire, 4);
          prev_idx = {ocg_idx, pt_idx};
          last_fire = cyc;
          td_cnt = done_dly;
          if (tiles == abort_tile) abort_arm = 1;
        end
        if (td_cnt == 0) begin
          tile_done = 1'b1; td_cnt = -1; last_td = cyc;
        end else if (td_cnt > 0) begin
          td_cnt--;
        end
        if (spur_en && state_dbg == S_COMPUTE && cyc == last_fire + 1 && !tile_done) begin
          start = 1'b1; wload_ack = 1'b1;
          cfg_last_pt  = exp_last_pt + PT_W'(3);
          cfg_last_ocg = exp_last_ocg + OCG_W'(1);
          cfg_mode     = ~exp_mode;
          cfg_nif_mult_k_mult_k = exp_nif + 32'd1;
          spur_pend = 1; spur_state = S_COMPUTE; spur_idx = {ocg_idx, pt_idx};
        end
        if (done) begin
          done_pulses++;
          done_cyc = cyc;
          chk("done_latency", cyc, last_td + 2);
          chk("mode_latched", mode, exp_mode);
          chk("nif_latched", nif_mult_k_mult_k, exp_nif);
        end else if (done_cyc >= 0 && cyc == done_cyc + 1) begin
          chk("idle_after_done", state_dbg, S_IDLE);
          chk("busy_after_done", busy, 1'b0);
          chk("idx_final", {ocg_idx, pt_idx}, {exp_last_ocg, exp_last_pt});
        end else if (done_cyc >= 0 && cyc == done_cyc + 2) begin
`ifdef CONV_SCHED_PERF_EN
          chk("perf_busy", perf_busy_cycles, done_cyc - first_cyc + 1);
`endif
          finished = 1;
        end
      end
    end
    if (!finished) chk("layer_timeout", finished, 1'b1);
  endtask

  task automatic check_layer(input string tag, input int exp_tiles, input int exp_wreq);
    chk({tag, "_tiles"}, tiles, exp_tiles);
    chk({tag, "_wload_eps"}, wreq_eps, exp_wreq);
    chk({tag, "_done_pulses"}, done_pulses, 1);
    chk({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1; start = 1'b0; cfg_mode = 1'b0; cfg_nif_mult_k_mult_k = '0;
    cfg_last_ocg = '0; cfg_last_pt = '0; wload_ack = 1'b0; fm_valid = 1'b1; tile_done = 1'b0;
    ack_dly = 2; done_dly = 40; stall_n = 0; abort_tile = 0; spur_en = 0; gap_chk = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_outputs("reset");

    // basic layer: 2 groups x 3 tiles
    start_layer(1'b0, 32'd1234, 1, 2);
    run_layer(2000);
    check_layer("basic", 6, 2);

    // single tile
    done_dly = 5;
    start_layer(1'b1, 32'd35, 0, 0);
    run_layer(500);
    check_layer("single", 1, 1);

    // feature-map stall of 10 cycles on the first tile
    stall_n = 10;
    start_layer(1'b0, 32'd77, 0, 1);
    run_layer(500);
    check_layer("stall", 2, 1);
`ifdef CONV_SCHED_PERF_EN
    chk("perf_fm_stall", perf_fm_stall_cycles, 10);
`endif

    // spurious start/ack/tile_done and cfg changes while busy
    stall_n = 4; spur_en = 1; done_dly = 6;
    start_layer(1'b1, 32'd99, 1, 1);
    run_layer(1000);
    check_layer("spurious", 4, 2);
    stall_n = 0; spur_en = 0;

    // reset during COMPUTE of tile (0,1), then a full layer from scratch
    done_dly = 40; abort_tile = 2;
    start_layer(1'b1, 32'd5, 1, 2);
    run_layer(1000);
    chk("abort_tiles", tiles, 2);
    abort_tile = 0;
    start_layer(1'b0, 32'd6, 1, 2);
    run_layer(2000);
    check_layer("after_abort", 6, 2);

    // back-to-back: ack with the request, tile_done in the first COMPUTE cycle
    ack_dly = 0; done_dly = 1; gap_chk = 1;
    start_layer(1'b1, 32'd8, 1, 3);
    run_layer(500);
    check_layer("b2b", 8, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/conv_tile_scheduler.md
# conv_tile_scheduler

Layer-level scheduler that sequences the SA/E/ReLU/Quantify tile controller across a full convolution layer. It walks output-channel groups (16 channels each, matching the SA row count) in the outer loop and pixel tiles in the inner loop. For each tile it requests weight loads, waits for feature-map readiness, fires the one-cycle `re_fm_en` start pulse, and waits for the tile-completion strobe. Exactly one tile is in flight at a time. The block sits between the layer descriptor/host interface and the tile controller.

## Interface
Parameters:
- `OCG_W`, 8: width of the output-channel-group index.
- `PT_W`, 16: width of the pixel-tile index.
- `PERF_W`, 32: width of the performance counters (used only with `CONV_SCHED_PERF_EN`).

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  layer start pulse; accepted only in IDLE.
- `cfg_mode`  in  1  layer mode (1 = mult-array mode); latched at start.
- `cfg_nif_mult_k_mult_k`  in  32  pixel-count bound; latched at start.
- `cfg_last_ocg`  in  OCG_W  last output-group index (value N gives N+1 groups); latched.
- `cfg_last_pt`  in  PT_W  last pixel-tile index; latched.
- `wload_req`  out  1  weight load request for `ocg_idx`; level signal.
- `wload_ack`  in  1  weights for `ocg_idx` resident; pulse.
- `fm_valid`  in  1  feature-map buffer holds tile `pt_idx`; level signal.
- `re_fm_en`  out  1  tile start pulse to the tile controller.
- `tile_done`  in  1  tile completion strobe (the tile controller's relu/scale end pulse).
- `mode`  out  1  latched `cfg_mode`.
- `nif_mult_k_mult_k`  out  32  latched `cfg_nif_mult_k_mult_k`.
- `ocg_idx`  out  OCG_W  current output group.
- `pt_idx`  out  PT_W  current pixel tile.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle layer-complete pulse.

## Operation
- FSM states: IDLE, LOAD_W, WAIT_FM, FIRE, COMPUTE, NEXT, DONE.
- **IDLE**: when `start` is high, latch all `cfg_*` inputs, clear both indices, go to LOAD_W.
- **LOAD_W**: `wload_req` is high. When `wload_ack` is high, go to WAIT_FM. An ack in the first LOAD_W cycle is valid.
- **WAIT_FM**: when `fm_valid` is high, go to FIRE.
- **FIRE**: `re_fm_en` is high for exactly this one cycle. Next state is COMPUTE.
- **COMPUTE**: when `tile_done` is high, go to NEXT.
- **NEXT**, one cycle; evaluated in this order:
  - `pt_idx` < `cfg_last_pt`: increment `pt_idx`, go to WAIT_FM. Weights are reused.
  - else if `ocg_idx` < last: clear `pt_idx`, increment `ocg_idx`, go to LOAD_W.
  - else: go to DONE.
- **DONE**: `done` is high for one cycle, then IDLE. Indices hold their final values until the next start.
- Ignored events:
  - `start` while busy.
  - `wload_ack` outside LOAD_W.
  - `tile_done` outside COMPUTE.
  - `cfg_*` changes while busy.
- A zero-sized configuration (`cfg_last_ocg` = 0, `cfg_last_pt` = 0) runs exactly one tile.
- `reset` mid-layer returns the FSM to IDLE immediately. The tile controller must be reset in the same cycle; that is the system's responsibility.

## Timing
- Reset values:
  - State is IDLE.
  - `wload_req`, `re_fm_en`, `busy`, `done`, `mode` = 0.
  - `nif_mult_k_mult_k`, `ocg_idx`, `pt_idx` = 0.
  - Perf counters = 0.
- All outputs are registered or decoded from registered state. There is no combinational path from inputs to outputs.
- Latency figures (T = cycle in which the triggering input is sampled high):
  - `start` at T gives `busy` and `wload_req` at T+1.
  - `wload_ack` at T gives WAIT_FM at T+1. With `fm_valid` already high, `re_fm_en` is at T+2.
  - `tile_done` at T gives NEXT at T+1. With `fm_valid` high, the next `re_fm_en` is at T+3.
  - `done` comes 2 cycles after the final `tile_done`.
- Minimum overhead between tiles: 3 cycles within a group; 3 cycles plus the weight-load time on a group change.
- Index outputs are stable from FIRE through COMPUTE. The tile controller can use them for write-back addressing.

## Configuration
- `CONV_SCHED_PERF_EN` defined:
  - Adds output ports `perf_busy_cycles` [PERF_W] and `perf_fm_stall_cycles` [PERF_W].
  - `perf_busy_cycles` counts cycles with `busy` high.
  - `perf_fm_stall_cycles` counts WAIT_FM cycles with `fm_valid` low.
  - Both counters saturate at all-ones, clear on start acceptance and on reset, and hold their values after DONE.
- `CONV_SCHED_PERF_EN` undefined: the ports and the counter logic are absent; all other behaviour is identical.

## Structure
- Shared package `conv_sched_pkg` holds:
  - the state enum `sched_state_t`;
  - `SA_ROWS` = 16;
  - default `OCG_W`, `PT_W` and `PERF_W`.
- One sub-module, `sched_perf_cnt`: a saturating counter with clear and enable, instantiated twice. It is instantiated only under `CONV_SCHED_PERF_EN`.

## Test plan
- **Basic layer**: `cfg_last_ocg` = 1, `cfg_last_pt` = 2, `wload_ack` 2 cycles after each request, `fm_valid` held high, `tile_done` 40 cycles after each `re_fm_en`.
  - Required: 6 `re_fm_en` pulses.
  - Index sequence (ocg, pt) = (0,0), (0,1), (0,2), (1,0), (1,1), (1,2).
  - Exactly 2 `wload_req` episodes; one `done` pulse 2 cycles after the last `tile_done`.
- **Single tile**: `cfg_last_ocg` = 0, `cfg_last_pt` = 0, `nif_mult_k_mult_k` = 35.
  - Required: one `re_fm_en`, `nif_mult_k_mult_k` output = 35, `mode` follows `cfg_mode`, `done` pulses.
- **Feature-map stall**: `fm_valid` low for 10 cycles in WAIT_FM.
  - Required: no `re_fm_en` until the cycle after `fm_valid` rises.
  - With `CONV_SCHED_PERF_EN`: `perf_fm_stall_cycles` = 10.
- **Spurious inputs**: `start`, `wload_ack` and `tile_done` pulsed during COMPUTE or WAIT_FM, and `cfg_last_pt` changed mid-layer.
  - Required: no state or index change; the tile count follows the latched configuration.
- **Reset mid-layer**: assert `reset` during COMPUTE of tile (0,1).
  - Required: all outputs return to reset values the next cycle.
  - A new `start` runs a full layer from (0,0).
- **Back-to-back timing**: `wload_ack` in the same cycle as `wload_req` rises, `tile_done` in the first COMPUTE cycle.
  - Required: `re_fm_en` 2 cycles after the ack.
  - Within a group, consecutive `re_fm_en` pulses are 4 cycles apart.
